encoder_param_registered: RTL and testbench

ENCODER_PARAM_REGISTERED -- requirements
Module: encoder_param_registered

---
 rtl/encoder_param_registered.sv | 99 +++++++++
 tb/tb_encoder_param_registered.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/encoder_param_registered.sv
// rtl/encoder_param_registered.sv - registered priority encoder with fixed or round-robin priority
module encoder_param_registered #(
  parameter int N_LINES = 8,
  parameter int RR_MODE = 0,
  localparam int OUT_W = $clog2(N_LINES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [N_LINES-1:0] in_lines,
  output logic               in_ready,
  output logic               out_valid,
  output logic [OUT_W-1:0]   out_lines,
  input  logic               out_ready,
  output logic               out_multi,
  output logic               out_none
);

  logic               out_valid_q, out_valid_d;
  logic [OUT_W-1:0]   out_lines_q, out_lines_d;
  logic               out_multi_q, out_multi_d;
  logic               out_none_q,  out_none_d;
  logic [OUT_W-1:0]   ptr_q, ptr_d;

  logic [N_LINES-1:0] rot;
  logic [OUT_W-1:0]   fixed_idx;
  logic [OUT_W-1:0]   rot_idx;
  logic [OUT_W-1:0]   winner;
  logic               vec_none;
  logic               vec_multi;
  logic               in_xfer;

  assign in_ready = !out_valid_q || out_ready;
  assign in_xfer  = in_valid && in_ready;

  assign vec_none  = ~|in_lines;
  // clearing the lowest set bit leaves something only if two or more bits were set
  assign vec_multi = |(in_lines & (in_lines - N_LINES'(1)));

  // rotating right by ptr puts the search start at bit 0
  assign rot = N_LINES'({in_lines, in_lines} >> ptr_q);

  always_comb begin
    fixed_idx = '0;
    rot_idx   = '0;
    for (int i = N_LINES - 1; i >= 0; i--) begin
      if (in_lines[i]) fixed_idx = OUT_W'(i);
      if (rot[i])      rot_idx   = OUT_W'(i);
    end
  end

  // N_LINES is a power of two, so OUT_W-bit addition wraps modulo N_LINES
  always_comb begin
    winner = '0;
    if (!vec_none) begin
      if (RR_MODE != 0) winner = rot_idx + ptr_q;
      else              winner = fixed_idx;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_lines_d = out_lines_q;
    out_multi_d = out_multi_q;
    out_none_d  = out_none_q;
    ptr_d       = ptr_q;
    if (in_xfer) begin
      out_valid_d = 1'b1;
      out_lines_d = winner;
      out_multi_d = vec_multi;
      out_none_d  = vec_none;
      if (!vec_none) ptr_d = winner + OUT_W'(1);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_lines_q <= '0;
      out_multi_q <= 1'b0;
      out_none_q  <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_lines_q <= out_lines_d;
      out_multi_q <= out_multi_d;
      out_none_q  <= out_none_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_lines = out_lines_q;
  assign out_multi = out_multi_q;
  assign out_none  = out_none_q;

endmodule

// File: tb/tb_encoder_param_registered.sv
// tb/tb_encoder_param_registered.sv - directed bench for fixed and round-robin encoder instances
module tb_encoder_param_registered;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_lines;
  logic       out_ready;

  logic       in_ready0, out_valid0, out_multi0, out_none0;
  logic [2:0] out_lines0;
  logic       in_ready1, out_valid1, out_multi1, out_none1;
  logic [2:0] out_lines1;

  int n_checks;
  int n_fail;

  encoder_param_registered #(.N_LINES(8), .RR_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_lines(in_lines),
    .in_ready(in_ready0), .out_valid(out_valid0), .out_lines(out_lines0),
    .out_ready(out_ready), .out_multi(out_multi0), .out_none(out_none0)
  );

  encoder_param_registered #(.N_LINES(8), .RR_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_lines(in_lines),
    .in_ready(in_ready1), .out_valid(out_valid1), .out_lines(out_lines1),
    .out_ready(out_ready), .out_multi(out_multi1), .out_none(out_none1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL rst_valid0 got %b want 0", out_valid0); end
    n_checks++; if (out_lines0 !== 3'd0) begin n_fail++; $display("FAIL rst_lines0 got %0d want 0", out_lines0); end
    n_checks++; if (out_multi0 !== 1'b0) begin n_fail++; $display("FAIL rst_multi0 got %b want 0", out_multi0); end
    n_checks++; if (out_none0 !== 1'b0) begin n_fail++; $display("FAIL rst_none0 got %b want 0", out_none0); end
    n_checks++; if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL rst_ready0 got %b want 1", in_ready0); end
    n_checks++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL rst_valid1 got %b want 0", out_valid1); end
    n_checks++; if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL rst_ready1 got %b want 1", in_ready1); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_lines = 8'b0000_0100; out_ready = 1'b1;
    tick();
    n_checks++; if (out_valid0 !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", out_valid0); end
    n_checks++; if (out_lines0 !== 3'd2) begin n_fail++; $display("FAIL single_lines got %0d want 2", out_lines0); end
    n_checks++; if (out_multi0 !== 1'b0) begin n_fail++; $display("FAIL single_multi got %b want 0", out_multi0); end
    n_checks++; if (out_none0 !== 1'b0) begin n_fail++; $display("FAIL single_none got %b want 0", out_none0); end
  endtask

  task automatic test_multi_none();
    in_lines = 8'b1001_0000;
    tick();
    n_checks++; if (out_lines0 !== 3'd4) begin n_fail++; $display("FAIL multi_lines got %0d want 4", out_lines0); end
    n_checks++; if (out_multi0 !== 1'b1) begin n_fail++; $display("FAIL multi_flag got %b want 1", out_multi0); end
    n_checks++; if (out_none0 !== 1'b0) begin n_fail++; $display("FAIL multi_none got %b want 0", out_none0); end
    in_lines = 8'h00;
    tick();
    n_checks++; if (out_lines0 !== 3'd0) begin n_fail++; $display("FAIL none_lines got %0d want 0", out_lines0); end
    n_checks++; if (out_none0 !== 1'b1) begin n_fail++; $display("FAIL none_flag got %b want 1", out_none0); end
    n_checks++; if (out_multi0 !== 1'b0) begin n_fail++; $display("FAIL none_multi got %b want 0", out_multi0); end
    n_checks++; if (out_valid0 !== 1'b1) begin n_fail++; $display("FAIL none_valid got %b want 1", out_valid0); end
  endtask

  task automatic test_backpressure();
    in_lines = 8'b0010_0000;
    tick();
    n_checks++; if (out_lines0 !== 3'd5) begin n_fail++; $display("FAIL bp_first got %0d want 5", out_lines0); end
    out_ready = 1'b0; in_lines = 8'b0000_0001;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++; if (in_ready0 !== 1'b0) begin n_fail++; $display("FAIL bp_ready cycle %0d got %b want 0", c, in_ready0); end
      n_checks++; if (out_valid0 !== 1'b1) begin n_fail++; $display("FAIL bp_valid cycle %0d got %b want 1", c, out_valid0); end
      n_checks++; if (out_lines0 !== 3'd5) begin n_fail++; $display("FAIL bp_hold cycle %0d got %0d want 5", c, out_lines0); end
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", in_ready0); end
    tick();
    n_checks++; if (out_valid0 !== 1'b1) begin n_fail++; $display("FAIL bp_next_valid got %b want 1", out_valid0); end
    n_checks++; if (out_lines0 !== 3'd0) begin n_fail++; $display("FAIL bp_next_lines got %0d want 0", out_lines0); end
    in_valid = 1'b0;
    tick();
    n_checks++; if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL drain_valid got %b want 0", out_valid0); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_rr [3];
    exp_rr[0] = 3'd0; exp_rr[1] = 3'd7; exp_rr[2] = 3'd0;
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    in_valid = 1'b1; in_lines = 8'b1000_0001; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (out_lines1 !== exp_rr[k]) begin n_fail++; $display("FAIL rr_lines step %0d got %0d want %0d", k, out_lines1, exp_rr[k]); end
      n_checks++; if (out_multi1 !== 1'b1) begin n_fail++; $display("FAIL rr_multi step %0d got %b want 1", k, out_multi1); end
      n_checks++; if (out_lines0 !== 3'd0) begin n_fail++; $display("FAIL fixed_ignores_ptr step %0d got %0d want 0", k, out_lines0); end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_lines = 8'(1) << i;
      tick();
      n_checks++; if (out_valid0 !== 1'b1 || out_valid1 !== 1'b1) begin n_fail++; $display("FAIL stream_valid idx %0d got %b/%b want 1/1", i, out_valid0, out_valid1); end
      n_checks++; if (out_lines0 !== 3'(i)) begin n_fail++; $display("FAIL stream_lines0 idx %0d got %0d want %0d", i, out_lines0, i); end
      n_checks++; if (out_lines1 !== 3'(i)) begin n_fail++; $display("FAIL stream_lines1 idx %0d got %0d want %0d", i, out_lines1, i); end
      n_checks++; if (out_multi1 !== 1'b0 || out_none1 !== 1'b0) begin n_fail++; $display("FAIL stream_flags idx %0d got %b%b want 00", i, out_multi1, out_none1); end
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_checks++; if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b/%b want 0/0", out_valid0, out_valid1); end
    n_checks++; if (out_lines1 !== 3'd0) begin n_fail++; $display("FAIL midrst_lines got %0d want 0", out_lines1); end
    n_checks++; if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %b want 1", in_ready1); end
    reset = 1'b0;
    in_valid = 1'b1; in_lines = 8'hFF;
    tick();
    n_checks++; if (out_lines1 !== 3'd0) begin n_fail++; $display("FAIL post_rst_ff got %0d want 0", out_lines1); end
    n_checks++; if (out_multi1 !== 1'b1) begin n_fail++; $display("FAIL post_rst_multi got %b want 1", out_multi1); end
    tick();
    n_checks++; if (out_lines1 !== 3'd1) begin n_fail++; $display("FAIL rr_second_ff got %0d want 1", out_lines1); end
    in_lines = 8'h00;
    tick();
    n_checks++; if (out_none1 !== 1'b1 || out_lines1 !== 3'd0) begin n_fail++; $display("FAIL rr_zero got none=%b lines=%0d want 1/0", out_none1, out_lines1); end
    in_lines = 8'hFF;
    tick();
    n_checks++; if (out_lines1 !== 3'd2) begin n_fail++; $display("FAIL rr_ptr_kept got %0d want 2", out_lines1); end
    in_lines = 8'b0000_0011;
    tick();
    n_checks++; if (out_lines1 !== 3'd0 || out_lines0 !== 3'd0) begin n_fail++; $display("FAIL rr_wrap_search got %0d/%0d want 0/0", out_lines1, out_lines0); end
    in_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b1; in_valid = 1'b0; in_lines = 8'h00; out_ready = 1'b1;
    test_reset();
    test_single();
    test_multi_none();
    test_backpressure();
    test_round_robin();
    test_back_to_back();
    test_reset_mid();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
